cover_toggle_collector: RTL and testbench
=========================================

COVER_TOGGLE_COLLECTOR -- requirements
Module: cover_toggle_collector

Interface
REQ-001 SHALL have parameter COVER_TOTAL, default 8744, number of toggle cover points tracked.
REQ-002 SHALL have parameter WIDTH, default 58, bits per incoming hit vector (1..64).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, power of two, depth of the hit-vector queue.
REQ-004 SHALL have port clock  input  1  single clock; all logic on posedge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have ports hit_valid input 1, hit_ready output 1, hit_base input 14, hit_vec input WIDTH: per-cycle toggle hits; bit i means cover index hit_base+i.
REQ-007 SHALL have ports new_valid output 1, new_index output 14: one-cycle pulse per first-time hit.
REQ-008 SHALL have ports covered_count output 14 (distinct points hit) and err_oor output 1 (sticky out-of-range flag).
REQ-009 SHALL have ports rd_en input 1, rd_addr input 8, rd_valid output 1, rd_data output 64: bitmap word readout.
REQ-010 SHALL have ports clear input 1 (pulse) and busy output 1.

Function
REQ-011 SHALL store a bitmap of COVER_TOTAL bits as ceil(COVER_TOTAL/64) 64-bit words (137 at default); bit b of word w is index 64*w+b.
REQ-012 SHALL accept a vector when hit_valid && hit_ready; hit_ready = FIFO not full && state != CLEAR.
REQ-013 SHALL drop accepted vectors with hit_vec == 0 without entering the FIFO.
REQ-014 SHALL run FSM IDLE -> SCAN when FIFO non-empty; SCAN -> IDLE when current vector exhausted and FIFO empty; any state -> CLEAR on clear; CLEAR -> IDLE after last word zeroed.
REQ-015 SHALL in SCAN process exactly one set bit per cycle, lowest bit first, clearing it from the working copy; pop the next FIFO entry the cycle the last bit is processed (no bubble).
REQ-016 SHALL for a processed index already set in the bitmap do nothing further.
REQ-017 SHALL for a processed index not yet set: set the bit, increment covered_count, and assert new_valid with new_index on the following cycle.
REQ-018 SHALL for index >= COVER_TOTAL (including 14-bit wrap of hit_base+i) not touch the bitmap, set err_oor, emit nothing.
REQ-019 SHALL produce rd_valid and rd_data one cycle after rd_en; rd_data is the pre-update word if the same word is updated that cycle; rd_addr beyond last word returns 0.
REQ-020 SHALL on clear: flush FIFO, abort current scan, zero covered_count and err_oor on the next cycle, zero one bitmap word per cycle (137 cycles default); clear during CLEAR restarts from word 0.
REQ-021 SHALL assert busy whenever state != IDLE or FIFO non-empty.
REQ-022 SHALL never exceed COVER_TOTAL in covered_count (guaranteed by REQ-016/018; no wrap).

Reset
REQ-023 SHALL on reset low: state IDLE, FIFO empty, covered_count 0, err_oor 0, new_valid 0, new_index 0, rd_valid 0, rd_data 0, busy 0, hit_ready 0 during reset.
REQ-024 SHALL zero the bitmap on reset via the CLEAR sequence started at reset release (busy high, hit_ready low for its duration).

Structure
REQ-025 SHALL place COVER_TOTAL default, index width (14), word width (64), word-count function and FSM state enum in shared package cover_toggle_pkg.
REQ-026 SHALL implement the queue as sub-module cover_hit_fifo (synchronous, valid/ready, FIFO_DEPTH entries of {hit_base, hit_vec}).

Verification
REQ-027 SHALL cover: after reset completes, hit_base=0, hit_vec=0x5 -> new_index 0 then 2 on consecutive cycles, covered_count=2.
REQ-028 SHALL cover: repeat of hit_base=0, hit_vec=0x5 -> no new_valid, covered_count stays 2; read rd_addr=0 -> rd_data=0x5.
REQ-029 SHALL cover: hit_base=8740, hit_vec=0xFF -> new_index 8740..8743, err_oor=1, covered_count +4.
REQ-030 SHALL cover: 6 back-to-back full vectors (WIDTH bits set, hit_base 0,58,...,290) -> hit_ready drops when FIFO full, all 348 indices reported once, no bubbles.
REQ-031 SHALL cover: clear mid-SCAN -> no further new_valid, busy high 137 cycles, covered_count=0, all rd_data=0 afterwards.
REQ-032 SHALL cover: reset low mid-SCAN for one cycle -> outputs at REQ-023 values, previously hit index reported again as new.

Source files
------------

// File: rtl/cover_toggle_pkg.sv
// Shared constants, word-count helper and FSM state type for the toggle coverage collector.
package cover_toggle_pkg;

    localparam int unsigned COVER_TOTAL_DEF = 8744;
    localparam int unsigned IDX_W           = 14;
    localparam int unsigned WORD_W          = 64;

    function automatic int unsigned word_count(input int unsigned total);
        return (total + WORD_W - 1) / WORD_W;
    endfunction

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StClear
    } state_t;

endpackage

// File: rtl/cover_hit_fifo.sv
// Small synchronous valid/ready queue holding {hit_base, hit_vec} entries.
module cover_hit_fifo #(
    parameter int unsigned DATA_W = 72,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       cnt_q;
    logic              push;
    logic              pop;

    assign in_ready  = (cnt_q != FULL_CNT);
    assign out_valid = (cnt_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

endmodule

// File: rtl/cover_toggle_collector.sv
// Toggle coverage collector: queues hit vectors, scans one set bit per cycle into a
// word-organised bitmap, reports first-time hits and supports word readout and clearing.
module cover_toggle_collector
    import cover_toggle_pkg::*;
#(
    parameter int unsigned COVER_TOTAL = COVER_TOTAL_DEF,
    parameter int unsigned WIDTH       = 58,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              hit_valid,
    output logic              hit_ready,
    input  logic [IDX_W-1:0]  hit_base,
    input  logic [WIDTH-1:0]  hit_vec,
    output logic              new_valid,
    output logic [IDX_W-1:0]  new_index,
    output logic [IDX_W-1:0]  covered_count,
    output logic              err_oor,
    input  logic              rd_en,
    input  logic [7:0]        rd_addr,
    output logic              rd_valid,
    output logic [WORD_W-1:0] rd_data,
    input  logic              clear,
    output logic              busy
);

    localparam int unsigned NWORDS    = word_count(COVER_TOTAL);
    localparam int unsigned WA        = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int unsigned LAST_WORD = NWORDS - 1;
    localparam logic [WA-1:0]  LAST_PTR  = LAST_WORD[WA-1:0];
    localparam logic [7:0]     LAST_ADDR = LAST_WORD[7:0];
    localparam logic [IDX_W:0] TOTAL_EXT = COVER_TOTAL[IDX_W:0];
    localparam int unsigned FW = IDX_W + WIDTH;

    function automatic logic [5:0] lowest_bit(input logic [WIDTH-1:0] v);
        lowest_bit = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) lowest_bit = 6'(i);
        end
    endfunction

    state_t            state_q, state_d;
    logic              init_q, init_d;
    logic [WIDTH-1:0]  work_q, work_d;
    logic [IDX_W-1:0]  base_q, base_d;
    logic [WA-1:0]     clr_ptr_q, clr_ptr_d;
    logic [IDX_W-1:0]  count_q, count_d;
    logic              err_q, err_d;
    logic              nv_q, nv_d;
    logic [IDX_W-1:0]  ni_q, ni_d;
    logic              rd_valid_q;
    logic [WORD_W-1:0] rd_data_q;
    logic [WORD_W-1:0] bitmap_q [NWORDS];

    logic              fifo_in_ready;
    logic              fifo_push;
    logic              fifo_out_valid;
    logic              fifo_pop;
    logic [FW-1:0]     fifo_out_data;
    logic              start_clear;

    logic [5:0]        scan_lsb;
    logic [IDX_W:0]    scan_sum;
    logic [IDX_W-1:0]  scan_idx;
    logic              scan_oor;
    logic [WA-1:0]     scan_word;
    logic [5:0]        scan_bit;
    logic [WORD_W-1:0] cur_word;
    logic              scan_hit;
    logic [WIDTH-1:0]  work_rest;

    logic              bm_we;
    logic [WA-1:0]     bm_waddr;
    logic [WORD_W-1:0] bm_wdata;

    // init_q requests the bitmap-zeroing pass on the first cycle after reset release
    assign start_clear = clear || init_q;
    assign hit_ready   = reset && fifo_in_ready && (state_q != StClear) && !init_q;
    assign fifo_push   = hit_valid && hit_ready && (hit_vec != '0);
    assign busy        = (state_q != StIdle) || fifo_out_valid || (init_q && reset);

    cover_hit_fifo #(
        .DATA_W (FW),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (start_clear),
        .in_valid  (fifo_push),
        .in_ready  (fifo_in_ready),
        .in_data   ({hit_base, hit_vec}),
        .out_valid (fifo_out_valid),
        .out_ready (fifo_pop),
        .out_data  (fifo_out_data)
    );

    // Index arithmetic keeps the carry so a 14-bit wrap is still seen as out of range
    assign scan_lsb  = lowest_bit(work_q);
    assign scan_sum  = {1'b0, base_q} + {{(IDX_W - 5){1'b0}}, scan_lsb};
    assign scan_idx  = scan_sum[IDX_W-1:0];
    assign scan_oor  = (scan_sum >= TOTAL_EXT);
    assign scan_word = scan_idx[WA+5:6];
    assign scan_bit  = scan_idx[5:0];
    assign cur_word  = scan_oor ? '0 : bitmap_q[scan_word];
    assign scan_hit  = cur_word[scan_bit];
    assign work_rest = work_q & (work_q - WIDTH'(1));

    always_comb begin
        state_d   = state_q;
        init_d    = init_q;
        work_d    = work_q;
        base_d    = base_q;
        clr_ptr_d = clr_ptr_q;
        count_d   = count_q;
        err_d     = err_q;
        nv_d      = 1'b0;
        ni_d      = ni_q;
        fifo_pop  = 1'b0;
        bm_we     = 1'b0;
        bm_waddr  = '0;
        bm_wdata  = '0;
        if (start_clear) begin
            state_d   = StClear;
            init_d    = 1'b0;
            work_d    = '0;
            clr_ptr_d = '0;
            count_d   = '0;
            err_d     = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (fifo_out_valid) begin
                        fifo_pop         = 1'b1;
                        {base_d, work_d} = fifo_out_data;
                        state_d          = StScan;
                    end
                end
                StScan: begin
                    if (work_q != '0) begin
                        if (scan_oor) begin
                            err_d = 1'b1;
                        end else if (!scan_hit) begin
                            bm_we    = 1'b1;
                            bm_waddr = scan_word;
                            bm_wdata = cur_word | (64'd1 << scan_bit);
                            count_d  = count_q + IDX_W'(1);
                            nv_d     = 1'b1;
                            ni_d     = scan_idx;
                        end
                    end
                    work_d = work_rest;
                    if (work_rest == '0) begin
                        if (fifo_out_valid) begin
                            fifo_pop         = 1'b1;
                            {base_d, work_d} = fifo_out_data;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                StClear: begin
                    bm_we     = 1'b1;
                    bm_waddr  = clr_ptr_q;
                    clr_ptr_d = clr_ptr_q + WA'(1);
                    if (clr_ptr_q == LAST_PTR) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= StIdle;
            init_q     <= 1'b1;
            work_q     <= '0;
            base_q     <= '0;
            clr_ptr_q  <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
            nv_q       <= 1'b0;
            ni_q       <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            init_q     <= init_d;
            work_q     <= work_d;
            base_q     <= base_d;
            clr_ptr_q  <= clr_ptr_d;
            count_q    <= count_d;
            err_q      <= err_d;
            nv_q       <= nv_d;
            ni_q       <= ni_d;
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_data_q <= (rd_addr <= LAST_ADDR) ? bitmap_q[rd_addr[WA-1:0]] : '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset && bm_we) bitmap_q[bm_waddr] <= bm_wdata;
    end

    assign new_valid     = nv_q;
    assign new_index     = ni_q;
    assign covered_count = count_q;
    assign err_oor       = err_q;
    assign rd_valid      = rd_valid_q;
    assign rd_data       = rd_data_q;

endmodule

// File: tb/tb_cover_toggle_collector.sv
// Directed bench for cover_toggle_collector with a set-based reference model and per-cycle compare.
module tb_cover_toggle_collector;

    localparam int unsigned COVER_TOTAL = 8744;
    localparam int unsigned WIDTH       = 58;
    localparam int unsigned NWORDS      = 137;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              hit_valid = 1'b0;
    logic              hit_ready;
    logic [13:0]       hit_base = '0;
    logic [WIDTH-1:0]  hit_vec = '0;
    logic              new_valid;
    logic [13:0]       new_index;
    logic [13:0]       covered_count;
    logic              err_oor;
    logic              rd_en = 1'b0;
    logic [7:0]        rd_addr = '0;
    logic              rd_valid;
    logic [63:0]       rd_data;
    logic              clear = 1'b0;
    logic              busy;

    always #5 clock = ~clock;

    cover_toggle_collector #(
        .COVER_TOTAL (COVER_TOTAL),
        .WIDTH       (WIDTH),
        .FIFO_DEPTH  (4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .hit_valid     (hit_valid),
        .hit_ready     (hit_ready),
        .hit_base      (hit_base),
        .hit_vec       (hit_vec),
        .new_valid     (new_valid),
        .new_index     (new_index),
        .covered_count (covered_count),
        .err_oor       (err_oor),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .clear         (clear),
        .busy          (busy)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    bit no_new = 1'b0;

    // Reference model: set of covered indices, pending first-hit reports
    bit m_bm [COVER_TOTAL];
    int m_cnt = 0;
    bit m_err = 1'b0;
    int exp_q[$];

    int seen_idx[$];
    int seen_cyc[$];
    int cyc = 0;
    int nv_run = 0;
    int nv_max = 0;
    int stalls = 0;

    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < COVER_TOTAL; i++) m_bm[i] = 1'b0;
        m_cnt = 0;
        m_err = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_apply(input int b, input logic [WIDTH-1:0] v);
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) begin
                if (b + i >= COVER_TOTAL) m_err = 1'b1;
                else if (!m_bm[b + i]) begin
                    m_bm[b + i] = 1'b1;
                    m_cnt++;
                    exp_q.push_back(b + i);
                end
            end
        end
    endtask

    always @(negedge clock) begin
        cyc++;
        if (chk_en) begin
            if (new_valid) begin
                seen_idx.push_back(int'(new_index));
                seen_cyc.push_back(cyc);
                nv_run++;
                chk("new_valid_expected", new_valid, (!no_new && exp_q.size() > 0));
                if (!no_new && exp_q.size() > 0) chk("new_index", new_index, exp_q.pop_front());
            end else begin
                if (nv_run > nv_max) nv_max = nv_run;
                nv_run = 0;
            end
            if (!busy) begin
                chk("drained", exp_q.size(), 0);
                chk("covered_count", covered_count, m_cnt);
                chk("err_oor", err_oor, m_err);
            end
        end
    end

    // All driver tasks start and end one time unit after a rising edge
    task automatic send(input logic [13:0] b, input logic [WIDTH-1:0] v);
        bit acc;
        int guard;
        acc = 1'b0;
        guard = 0;
        hit_base = b;
        hit_vec = v;
        hit_valid = 1'b1;
        while (!acc && guard < 1000) begin
            @(negedge clock);
            acc = hit_ready;
            if (!acc) stalls++;
            @(posedge clock);
            #1;
            guard++;
        end
        hit_valid = 1'b0;
        chk("send_accepted", acc, 1'b1);
        if (acc) model_apply(int'(b), v);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        @(negedge clock);
        while (busy && guard < 3000) begin
            @(negedge clock);
            guard++;
        end
        chk("idle_within_budget", busy, 1'b0);
        @(negedge clock);
        @(posedge clock);
        #1;
    endtask

    task automatic rd_word(input logic [7:0] a, output logic [63:0] d, output logic v);
        rd_addr = a;
        rd_en = 1'b1;
        @(posedge clock);
        #1;
        rd_en = 1'b0;
        @(negedge clock);
        d = rd_data;
        v = rd_valid;
        @(posedge clock);
        #1;
    endtask

    task automatic rd_check(input string name, input logic [7:0] a, input logic [63:0] want);
        logic [63:0] d;
        logic v;
        rd_word(a, d, v);
        chk({name, "_valid"}, v, 1'b1);
        chk(name, d, want);
    endtask

    task automatic check_reset_outputs();
        chk("rst_new_valid", new_valid, 1'b0);
        chk("rst_new_index", new_index, 0);
        chk("rst_covered_count", covered_count, 0);
        chk("rst_err_oor", err_oor, 1'b0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_hit_ready", hit_ready, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cycles;
        model_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_outputs();
        reset = 1'b1;
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("init_clear_busy", busy, 1'b1);
        chk("init_clear_hit_ready", hit_ready, 1'b0);
        @(posedge clock);
        #1;
        wait_idle();
        chk_en = 1'b1;

        // First hits at index 0 and 2, reported on consecutive cycles
        seen_idx.delete();
        seen_cyc.delete();
        send(14'd0, 58'h5);
        wait_idle();
        chk("first_hits_count", seen_idx.size(), 2);
        if (seen_idx.size() == 2) begin
            chk("first_hit_0", seen_idx[0], 0);
            chk("first_hit_1", seen_idx[1], 2);
            chk("first_hits_adjacent", seen_cyc[1] - seen_cyc[0], 1);
        end
        chk("count_after_first", covered_count, 2);

        // Repeat: nothing new
        seen_idx.delete();
        send(14'd0, 58'h5);
        wait_idle();
        chk("repeat_no_new", seen_idx.size(), 0);
        chk("count_after_repeat", covered_count, 2);
        rd_check("rd_word0", 8'd0, 64'h5);

        // Top of range with overflow past COVER_TOTAL
        seen_idx.delete();
        send(14'd8740, 58'hFF);
        wait_idle();
        chk("top_hits_count", seen_idx.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < seen_idx.size()) chk("top_hit_index", seen_idx[k], 8740 + k);
        end
        chk("top_err_oor", err_oor, 1'b1);
        chk("top_count", covered_count, 6);
        rd_check("rd_word136", 8'd136, 64'h0000_00F0_0000_0000);

        // Zero vector is accepted but never queued
        send(14'd5, '0);
        @(negedge clock);
        chk("zero_vec_not_queued", busy, 1'b0);
        @(posedge clock);
        #1;

        // Clear in the middle of a scan
        seen_idx.delete();
        send(14'd100, ONES);
        repeat (10) @(posedge clock);
        #1;
        clear = 1'b1;
        @(posedge clock);
        #1;
        clear = 1'b0;
        model_reset();
        no_new = 1'b1;
        busy_cycles = 0;
        for (int g = 0; g < 1000; g++) begin
            @(negedge clock);
            if (!busy) break;
            busy_cycles++;
        end
        no_new = 1'b0;
        @(posedge clock);
        #1;
        chk("clear_busy_cycles", busy_cycles, NWORDS);
        chk("clear_partial_scan_seen", seen_idx.size() > 0, 1'b1);
        chk("clear_count", covered_count, 0);
        chk("clear_err", err_oor, 1'b0);
        for (int w = 0; w < NWORDS + 2; w++) rd_check("rd_after_clear", 8'(w), 64'h0);

        // 14-bit wrap of hit_base+i is out of range
        send(14'd16380, 58'h30);
        wait_idle();
        chk("wrap_err_oor", err_oor, 1'b1);
        chk("wrap_count", covered_count, 0);

        // Six back-to-back full vectors
        seen_idx.delete();
        nv_max = 0;
        stalls = 0;
        for (int k = 0; k < 6; k++) send(14'(58 * k), ONES);
        wait_idle();
        chk("burst_hit_ready_stalled", stalls > 0, 1'b1);
        chk("burst_reported", seen_idx.size(), 348);
        chk("burst_no_bubble_run", nv_max, 348);
        chk("burst_count", covered_count, 348);
        rd_check("rd_burst_w0", 8'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        rd_check("rd_burst_w5", 8'd5, 64'h0000_0000_0FFF_FFFF);
        rd_check("rd_beyond_137", 8'd137, 64'h0);
        rd_check("rd_beyond_255", 8'd255, 64'h0);

        // One-cycle reset in the middle of a scan
        send(14'd400, ONES);
        repeat (10) @(posedge clock);
        #1;
        chk_en = 1'b0;
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check_reset_outputs();
        reset = 1'b1;
        model_reset();
        @(posedge clock);
        #1;
        wait_idle();
        chk_en = 1'b1;
        seen_idx.delete();
        send(14'd0, 58'h1);
        wait_idle();
        chk("post_reset_new_count", seen_idx.size(), 1);
        if (seen_idx.size() == 1) chk("post_reset_new_index", seen_idx[0], 0);
        chk("post_reset_count", covered_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
